serial_adder_ctrl: RTL and testbench

Bit-serial add controller that time-shares a single 1-bit full-adder cell (one instance of mbledhesi1b) across a WIDTH-bit operation.
- Latches two operands on a START handshake.
- Feeds the cell one bit pair per clock, LSB first, and recirculates the carry through a flip-flop.
- Assembles the sum in a shift register and reports completion with a one-cycle DONE pulse.
- Serves as the small-area add unit for slow-path arithmetic where a parallel adder is not justified.

---
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry recirculated per clock.
// Define SERIAL_SUB_EN to add the SUB input (A-B via inverted B and carry-in 1).
module mbledhesi1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, sub_q, sub_in;
    logic             accept, last;
    logic             cell_b, cell_s, cell_co;

`ifdef SERIAL_SUB_EN
    assign sub_in = SUB;
`else
    assign sub_in = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                last = (cnt == CW'(WIDTH - 1));
                if (last) state_nxt = FIN;
            end
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction feeds ~B; the inversion is applied per bit at the cell.
    assign cell_b  = b_sr[0] ^ sub_q;
    assign sum_nxt = (sum_sr >> 1) | {cell_s, {(WIDTH-1){1'b0}}};

    mbledhesi1b u_cell (
        .a  (a_sr[0]),
        .b  (cell_b),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            RESULT <= '0;
            COUT   <= 1'b0;
            OVF    <= 1'b0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= sub_in ? 1'b1 : CIN;
            sub_q <= sub_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_nxt;
            carry  <= cell_co;
            cnt    <= cnt + CW'(1);
            if (last) begin
                RESULT <= sum_nxt;
                COUT   <= cell_co;
                // carry still holds the carry into the MSB here
                OVF    <= carry ^ cell_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8) with an arithmetic reference.
// Driver pushes expected results; a negedge monitor pops and compares them.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           acc;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int           cyc = 0;
    int           ncmp = 0;
    int           nfail = 0;
    exp_t         q[$];
    logic [W-1:0] held_res = '0;
    logic         held_co = 1'b0;
    logic         held_ov = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .A      (a),
        .B      (b),
        .CIN    (cin),
`ifdef SERIAL_SUB_EN
        .SUB    (sub),
`endif
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result),
        .COUT   (cout),
        .OVF    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer add of A, B (or ~B) and carry-in.
    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv,
                                   logic ci, logic sb, int acc);
        exp_t       e;
        logic [W-1:0] bb;
        logic [W:0] full;
        bb     = sb ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, bb} + (W+1)'(sb ? 1'b1 : ci);
        e.res  = full[W-1:0];
        e.co   = full[W];
        e.ov   = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
        e.acc  = acc;
        e.due  = acc + W + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy),
                  32'(q.size() > 0 && cyc > q[0].acc && cyc < q[0].due));
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", 32'(cyc - e.acc), 32'(W + 1));
                    check("result", 32'(result), 32'(e.res));
                    check("cout", 32'(cout), 32'(e.co));
                    check("ovf", 32'(ovf), 32'(e.ov));
                    held_res = e.res;
                    held_co  = e.co;
                    held_ov  = e.ov;
                end
            end else begin
                check("held_result", 32'(result), 32'(held_res));
                check("held_flags", 32'({cout, ovf}), 32'({held_co, held_ov}));
                if (q.size() > 0 && cyc > q[0].due) begin
                    check("done_timeout", 32'(done), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic set_junk();
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
`ifdef SERIAL_SUB_EN
        sub = 1'($urandom);
`endif
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (busy || done) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("idle_timeout", 32'(busy | done), 32'd0);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic issue(logic [W-1:0] av, logic [W-1:0] bv,
                         logic ci, logic sb);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        a   = av;
        b   = bv;
        cin = ci;
`ifdef SERIAL_SUB_EN
        sub = sb;
`endif
        start = 1'b1;
        q.push_back(model(av, bv, ci, sb, cyc));
        @(negedge clk);
        start = 1'b0;
        set_junk();
    endtask

    // START held high: each idle cycle accepts 3+4, A is disturbed in RUN.
    task automatic held_ops(int count);
        int k = 0;
        int n = 0;
        start = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!busy && !done) begin
                if (k == count) break;
                a   = 8'h03;
                b   = 8'h04;
                cin = 1'b0;
`ifdef SERIAL_SUB_EN
                sub = 1'b0;
`endif
                q.push_back(model(8'h03, 8'h04, 1'b0, 1'b0, cyc));
                k++;
            end else begin
                a = 8'h10;
                b = 8'($urandom);
            end
        end
        start = 1'b0;
        check("held_accepts", 32'(k), 32'(count));
    endtask

    task automatic reset_mid_run();
        issue(8'hA5, 8'h3C, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        q.delete();
        held_res = '0;
        held_co  = 1'b0;
        held_ov  = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #2;
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_outs", 32'({result, cout, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h00, 1'b1, 1'b0);
        held_ops(3);
        issue(8'h20, 8'h20, 1'b0, 1'b0);
        reset_mid_run();
        issue(8'h01, 8'h01, 1'b0, 1'b0);
`ifdef SERIAL_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1);
        issue(8'h80, 8'h01, 1'b1, 1'b1);
`endif
        issue(8'h80, 8'h80, 1'b0, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (40) begin
`ifdef SERIAL_SUB_EN
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
`else
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
`endif
        end

        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) check("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
